// File: rtl/serial_alu_seq_if.sv
// Operation request/response bus between execute-stage control and the
// bit-serial ALU sequencer: start/ready handshake, operands, op code,
// and the assembled result with flags and a one-cycle done pulse.
interface serial_alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic             ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             done_o;

    // Requesting side (pipeline control)
    modport master (
        output start_i, src1_i, src2_i, ctrl_i,
        input  ready_o, result_o, zero_o, cout_o, overflow_o, done_o
    );

    // Sequencer side
    modport slave (
        input  start_i, src1_i, src2_i, ctrl_i,
        output ready_o, result_o, zero_o, cout_o, overflow_o, done_o
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit ALU slice LSB-first
// over WIDTH cycles and assembles the result word and flags.
// Optional feature macro: SERIAL_ALU_SLT_EN enables the two-pass SLT
// sequence (SUB pass followed by an SLTSET pass); without it, SLT is
// treated as an unsupported op code.
module serial_alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    serial_alu_seq_if.slave      bus,
    output logic                 sl_a_o,
    output logic                 sl_b_o,
    output logic                 sl_inva_o,
    output logic                 sl_invb_o,
    output logic                 sl_null_o,
    output logic [1:0]           sl_op_o,
    output logic                 sl_cin_o,
    output logic                 sl_less_o,
    input  logic                 sl_res_i,
    input  logic                 sl_cout_i
);

    localparam int unsigned KW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef SERIAL_ALU_SLT_EN
    localparam logic [3:0] OP_SLT = 4'b0111;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
`ifdef SERIAL_ALU_SLT_EN
        S_SLTSET = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q;
    logic             c_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] src1_q, src2_q;
    logic [3:0]       ctrl_q;
`ifdef SERIAL_ALU_SLT_EN
    logic             set_q;
`endif
    logic             first_bit, last_bit;
    logic             is_add, is_sub, is_arith;

    assign first_bit = (k_q == '0);
    assign last_bit  = (k_q == KW'(WIDTH - 1));
    assign res_next  = {sl_res_i, res_q[WIDTH-1:1]};

    // Op-code classification of the latched control
    always_comb begin
        is_add = (ctrl_q == OP_ADD);
`ifdef SERIAL_ALU_SLT_EN
        is_sub = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
`else
        is_sub = (ctrl_q == OP_SUB);
`endif
        is_arith = is_add | is_sub;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start_i) state_d = S_RUN;
            S_RUN: begin
                if (last_bit) begin
`ifdef SERIAL_ALU_SLT_EN
                    state_d = (ctrl_q == OP_SLT) ? S_SLTSET : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SERIAL_ALU_SLT_EN
            S_SLTSET: if (last_bit) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and slice drive decoded from state and latched op
    always_comb begin
        bus.ready_o = (state_q == S_IDLE);
        bus.done_o  = (state_q == S_DONE);
        sl_a_o      = 1'b0;
        sl_b_o      = 1'b0;
        sl_inva_o   = 1'b0;
        sl_invb_o   = 1'b0;
        sl_null_o   = 1'b0;
        sl_op_o     = 2'b00;
        sl_cin_o    = 1'b0;
        sl_less_o   = 1'b0;
        case (state_q)
            S_RUN: begin
                sl_a_o = src1_q[k_q];
                sl_b_o = src2_q[k_q];
                if (is_add) begin
                    sl_op_o  = 2'b10;
                    sl_cin_o = first_bit ? 1'b0 : c_q;
                end else if (is_sub) begin
                    sl_op_o   = 2'b10;
                    sl_invb_o = 1'b1;
                    sl_cin_o  = first_bit ? 1'b1 : c_q;
                end else begin
                    case (ctrl_q)
                        OP_AND: sl_op_o = 2'b00;
                        OP_OR:  sl_op_o = 2'b01;
                        // Slice AND path ignores inversion, so invert here
                        OP_NOR: begin
                            sl_op_o = 2'b00;
                            sl_a_o  = ~src1_q[k_q];
                            sl_b_o  = ~src2_q[k_q];
                        end
                        default: begin
                            sl_op_o   = 2'b11;
                            sl_less_o = 1'b0;
                        end
                    endcase
                end
            end
`ifdef SERIAL_ALU_SLT_EN
            S_SLTSET: begin
                sl_op_o   = 2'b11;
                sl_less_o = first_bit ? set_q : 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Operand latch, bit counter, carry chain and result assembly
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            k_q            <= '0;
            c_q            <= 1'b0;
            res_q          <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            ctrl_q         <= '0;
`ifdef SERIAL_ALU_SLT_EN
            set_q          <= 1'b0;
`endif
            bus.result_o   <= '0;
            bus.zero_o     <= 1'b0;
            bus.cout_o     <= 1'b0;
            bus.overflow_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        src1_q <= bus.src1_i;
                        src2_q <= bus.src2_i;
                        ctrl_q <= bus.ctrl_i;
                        k_q    <= '0;
                        c_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    res_q <= res_next;
                    k_q   <= last_bit ? '0 : k_q + KW'(1);
                    if (is_arith) c_q <= sl_cout_i;
                    if (last_bit) begin
`ifdef SERIAL_ALU_SLT_EN
                        // Sign of a-b corrected for overflow seeds the SLT pass
                        set_q <= sl_res_i ^ c_q ^ sl_cout_i;
                        if (ctrl_q != OP_SLT) begin
`else
                        begin
`endif
                            bus.result_o   <= res_next;
                            bus.zero_o     <= (res_next == '0);
                            bus.cout_o     <= is_arith ? sl_cout_i : 1'b0;
                            bus.overflow_o <= is_arith ? (c_q ^ sl_cout_i) : 1'b0;
                        end
                    end
                end
`ifdef SERIAL_ALU_SLT_EN
                S_SLTSET: begin
                    res_q <= res_next;
                    k_q   <= last_bit ? '0 : k_q + KW'(1);
                    if (last_bit) begin
                        bus.result_o   <= res_next;
                        bus.zero_o     <= (res_next == '0);
                        bus.cout_o     <= 1'b0;
                        bus.overflow_o <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit ALU slice.
module tb_serial_alu_seq;
    localparam int unsigned WIDTH = 32;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       sl_a, sl_b, sl_inva, sl_invb, sl_null, sl_cin, sl_less;
    logic [1:0] sl_op;
    logic       sl_res, sl_cout;
    logic       a_eff, b_eff, sum;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus),
        .sl_a_o    (sl_a),
        .sl_b_o    (sl_b),
        .sl_inva_o (sl_inva),
        .sl_invb_o (sl_invb),
        .sl_null_o (sl_null),
        .sl_op_o   (sl_op),
        .sl_cin_o  (sl_cin),
        .sl_less_o (sl_less),
        .sl_res_i  (sl_res),
        .sl_cout_i (sl_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Behavioural 1-bit ALU slice
    always_comb begin
        a_eff   = (sl_a & ~sl_null) ^ sl_inva;
        b_eff   = sl_b ^ sl_invb;
        sum     = a_eff ^ b_eff ^ sl_cin;
        sl_cout = (a_eff & b_eff) | (a_eff & sl_cin) | (b_eff & sl_cin);
        case (sl_op)
            2'b00:   sl_res = sl_a & sl_b;
            2'b01:   sl_res = sl_a | sl_b;
            2'b10:   sum_sel();
            default: sl_res = sl_less;
        endcase
    end

    function automatic void sum_sel();
        sl_res = sum;
    endfunction

    // Issue one op and observe it; returns latency in cycles after accept (-1 on timeout)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                          input int pulse_at, output int lat, output int acc_cyc,
                          output logic [31:0] res, output logic z, output logic c, output logic v,
                          output logic [1:0] k0_op, output logic k0_cin, output logic k0_invb,
                          output logic k0_a, output logic k0_rdy, output logic d_rdy);
        int w;
        w = 0;
        while (bus.ready_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        acc_cyc    = cyc_cnt + 1;
        bus.start_i = 1'b1;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.ctrl_i  = ctrl;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.ctrl_i  = 4'b0000;
        k0_op   = sl_op;
        k0_cin  = sl_cin;
        k0_invb = sl_invb;
        k0_a    = sl_a;
        k0_rdy  = bus.ready_o;
        lat   = -1;
        res   = 'x;
        z     = 1'bx;
        c     = 1'bx;
        v     = 1'bx;
        d_rdy = 1'bx;
        for (int cyc = 1; cyc <= 3 * WIDTH; cyc++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat   = cyc;
                res   = bus.result_o;
                z     = bus.zero_o;
                c     = bus.cout_o;
                v     = bus.overflow_o;
                d_rdy = bus.ready_o;
                break;
            end
            if (cyc == pulse_at - 1) begin
                bus.start_i = 1'b1;
                bus.src1_i  = 32'hDEAD_BEEF;
                bus.ctrl_i  = 4'b0010;
            end
            if (cyc == pulse_at) begin
                bus.start_i = 1'b0;
                bus.src1_i  = '0;
                bus.ctrl_i  = 4'b0000;
            end
        end
    endtask

    int          lat, acc, acc2;
    logic [31:0] res;
    logic        z, c, v, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy;
    logic [1:0]  k0_op;

    task automatic test_reset();
        logic [8:0] sl_all;
        rst_i       = 1'b0;
        bus.start_i = 1'b0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.ctrl_i  = '0;
        repeat (3) @(negedge clk);
        sl_all = {sl_a, sl_b, sl_inva, sl_invb, sl_null, sl_op, sl_cin, sl_less};
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
        checks++; if ({bus.zero_o, bus.cout_o, bus.overflow_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.zero_o, bus.cout_o, bus.overflow_o}); end
        checks++; if (sl_all !== 9'h0) begin errors++; $display("FAIL reset_slice: got %h want 0", sl_all); end
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_op(32'd7, 32'd5, 4'b0010, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (lat != 32) begin errors++; $display("FAIL add_latency: got %0d want 32", lat); end
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL add_result: got %h want c", res); end
        checks++; if ({z, c, v} !== 3'b000) begin errors++; $display("FAIL add_flags: got %b want 000", {z, c, v}); end
        checks++; if ({k0_op, k0_cin, k0_invb} !== 4'b1000) begin errors++; $display("FAIL add_slice_k0: got %b want 1000", {k0_op, k0_cin, k0_invb}); end
        checks++; if (k0_rdy !== 1'b0 || d_rdy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b%b want 00", k0_rdy, d_rdy); end
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL add_ready_after: got %b%b want 10", bus.ready_o, bus.done_o); end
        checks++; if (bus.result_o !== 32'd12) begin errors++; $display("FAIL add_hold: got %h want c", bus.result_o); end
    endtask

    task automatic test_sub();
        run_op(32'd5, 32'd7, 4'b0110, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg_result: got %h want fffffffe", res); end
        checks++; if ({z, c, v} !== 3'b000) begin errors++; $display("FAIL sub_neg_flags: got %b want 000", {z, c, v}); end
        checks++; if ({k0_op, k0_cin, k0_invb} !== 4'b1011) begin errors++; $display("FAIL sub_slice_k0: got %b want 1011", {k0_op, k0_cin, k0_invb}); end
        run_op(32'd9, 32'd9, 4'b0110, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL sub_eq_result: got %h want 0", res); end
        checks++; if ({z, c, v} !== 3'b110) begin errors++; $display("FAIL sub_eq_flags: got %b want 110", {z, c, v}); end
    endtask

    task automatic test_overflow();
        run_op(32'h7FFF_FFFF, 32'd1, 4'b0010, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result: got %h want 80000000", res); end
        checks++; if ({z, c, v} !== 3'b001) begin errors++; $display("FAIL ovf_flags: got %b want 001", {z, c, v}); end
    endtask

    task automatic test_logic();
        logic extra;
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'hF000_F000 || {c, v} !== 2'b00) begin errors++; $display("FAIL and_result: got %h/%b want f000f000/00", res, {c, v}); end
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or_result: got %h want fff0fff0", res); end
        run_op(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1100, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'h0000_F0F0) begin errors++; $display("FAIL nor_mix_result: got %h want 0000f0f0", res); end
        run_op(32'h0, 32'h0, 4'b1100, 5, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'hFFFF_FFFF || lat != 32) begin errors++; $display("FAIL nor_zero_result: got %h lat %0d want ffffffff lat 32", res, lat); end
        checks++; if ({k0_op, k0_a} !== 3'b001) begin errors++; $display("FAIL nor_slice_k0: got %b want 001", {k0_op, k0_a}); end
        extra = 1'b0;
        for (int i = 0; i < 2 * WIDTH + 4; i++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL nor_ignored_start: got extra done %b want 0", extra); end
    endtask

    task automatic test_unsupported();
        run_op(32'hFFFF_FFFF, 32'h1234_5678, 4'b0011, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'h0 || {c, v} !== 2'b00 || lat != 32) begin errors++; $display("FAIL unsup_result: got %h/%b lat %0d want 0/00 lat 32", res, {c, v}, lat); end
        checks++; if (k0_op !== 2'b11) begin errors++; $display("FAIL unsup_slice_k0: got %b want 11", k0_op); end
    endtask

    task automatic test_slt();
`ifdef SERIAL_ALU_SLT_EN
        run_op(32'hFFFF_FFFF, 32'd1, 4'b0111, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'd1 || lat != 64) begin errors++; $display("FAIL slt_neg: got %h lat %0d want 1 lat 64", res, lat); end
        checks++; if ({c, v} !== 2'b00 || {k0_op, k0_cin, k0_invb} !== 4'b1011) begin errors++; $display("FAIL slt_flags_k0: got %b %b want 00 1011", {c, v}, {k0_op, k0_cin, k0_invb}); end
        run_op(32'h8000_0000, 32'd1, 4'b0111, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'd1) begin errors++; $display("FAIL slt_ovf: got %h want 1", res); end
        run_op(32'd5, 32'd3, 4'b0111, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL slt_false: got %h z %b want 0 z 1", res, z); end
`else
        run_op(32'hFFFF_FFFF, 32'd1, 4'b0111, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'h0 || {c, v} !== 2'b00 || lat != 32) begin errors++; $display("FAIL slt_unsup: got %h/%b lat %0d want 0/00 lat 32", res, {c, v}, lat); end
`endif
    endtask

    task automatic test_back_to_back();
        run_op(32'd100, 32'd23, 4'b0010, 0, lat, acc, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'd123) begin errors++; $display("FAIL b2b_first: got %h want 7b", res); end
        run_op(32'd50, 32'd8, 4'b0110, 0, lat, acc2, res, z, c, v, k0_op, k0_cin, k0_invb, k0_a, k0_rdy, d_rdy);
        checks++; if (res !== 32'd42 || {z, c, v} !== 3'b010) begin errors++; $display("FAIL b2b_second: got %h/%b want 2a/010", res, {z, c, v}); end
        checks++; if (acc2 - acc != WIDTH + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc2 - acc, WIDTH + 2); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] sl_all;
        logic       extra;
        bus.start_i = 1'b1;
        bus.src1_i  = 32'h7FFF_FFFF;
        bus.src2_i  = 32'd1;
        bus.ctrl_i  = 4'b0010;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        sl_all = {sl_a, sl_b, sl_inva, sl_invb, sl_null, sl_op, sl_cin, sl_less};
        checks++; if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL abort_handshake: got %b%b want 10", bus.ready_o, bus.done_o); end
        checks++; if (bus.result_o !== 32'h0 || {bus.zero_o, bus.cout_o, bus.overflow_o} !== 3'b000) begin errors++; $display("FAIL abort_outputs: got %h/%b want 0/000", bus.result_o, {bus.zero_o, bus.cout_o, bus.overflow_o}); end
        checks++; if (sl_all !== 9'h0) begin errors++; $display("FAIL abort_slice: got %h want 0", sl_all); end
        rst_i = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 2 * WIDTH + 4; i++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.ready_o !== 1'b1) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity %b want 0", extra); end
    endtask

    initial begin
        rst_i       = 1'b0;
        bus.start_i = 1'b0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.ctrl_i  = '0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_logic();
        test_unsupported();
        test_slt();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
